// File: rtl/alu_pkg.sv
// Shared types and defaults for the sequential ALU (alu_seq) and its
// iterative multiplier. Multiply support is gated by the ALU_MUL_EN macro.
package alu_pkg;

  localparam int ALU_WIDTH = 24;
  localparam int ALU_NREG  = 8;

  typedef enum logic [3:0] {
    OP_PASSA = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_XOR   = 4'd5,
    OP_SHL1  = 4'd6,
    OP_SHR1  = 4'd7,
    OP_INC   = 4'd8,
    OP_MUL   = 4'd9
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Request/result bundle between the issuing control logic and alu_seq.
// busy only ever rises when the design is built with ALU_MUL_EN.
interface alu_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int NREG  = ALU_NREG
);
  localparam int DW = (NREG > 1) ? $clog2(NREG) : 1;

  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [DW-1:0]    dest;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] C_bus;
  logic [NREG-1:0]  load;
  logic             z;
  logic             err;

  modport master (output start, op, a, b, dest,
                  input  busy, done, C_bus, load, z, err);
  modport slave  (input  start, op, a, b, dest,
                  output busy, done, C_bus, load, z, err);
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per clock, WIDTH steps.
// done_o/result_o are combinational off the step registers so the parent
// can commit the product on the same edge as the final step.
// Only instantiated when ALU_MUL_EN is defined.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);
  localparam int CW = $clog2(WIDTH);

  logic             run_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mplier_q;

  assign acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o   = run_q && (cnt_q == CW'(WIDTH - 1));
  assign result_o = acc_d;

  // Load operands on start, then accumulate one multiplier bit per clock
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else if (start_i && !run_q) begin
      run_q    <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= a_i;
      mplier_q <= b_i;
    end else if (run_q) begin
      acc_q    <= acc_d;
      mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
      cnt_q    <= cnt_q + CW'(1);
      if (done_o) run_q <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Sequential ALU driving the C bus and one-hot GPR load strobes.
// Define ALU_MUL_EN to build op 9 as an iterative multiply; otherwise op 9
// is reported as illegal and busy stays low.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int NREG  = ALU_NREG
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] c_bus_q, c_bus_d;
  logic [NREG-1:0]  load_q, load_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             z_q, z_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_legal;
  logic [NREG-1:0]  dest_oh;

  // An out-of-range index shifts the bit off the end, leaving no strobe
  assign dest_oh = NREG'(1) << bus.dest;

`ifdef ALU_MUL_EN
  logic             mul_start, mul_done;
  logic [WIDTH-1:0] mul_res;
  logic [bus.DW-1:0] dest_q;
  logic [NREG-1:0]  dest_q_oh;

  assign mul_start = (state_q == S_IDLE) && bus.start && (bus.op == OP_MUL);
  assign dest_q_oh = NREG'(1) << dest_q;
  assign bus.busy  = (state_q == S_MUL);

  // Hold the destination across the multiply
  always_ff @(posedge clk) begin
    if (rst)                                 dest_q <= '0;
    else if (state_q == S_IDLE && bus.start) dest_q <= bus.dest;
  end

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mul_start),
    .a_i      (bus.a),
    .b_i      (bus.b),
    .done_o   (mul_done),
    .result_o (mul_res)
  );
`else
  assign bus.busy = 1'b0;
`endif

  // Single-cycle datapath and opcode legality
  always_comb begin
    alu_res   = '0;
    alu_legal = 1'b1;
    case (bus.op)
      OP_PASSA: alu_res = bus.a;
      OP_ADD:   alu_res = bus.a + bus.b;
      OP_SUB:   alu_res = bus.a - bus.b;
      OP_AND:   alu_res = bus.a & bus.b;
      OP_OR:    alu_res = bus.a | bus.b;
      OP_XOR:   alu_res = bus.a ^ bus.b;
      OP_SHL1:  alu_res = {bus.a[WIDTH-2:0], 1'b0};
      OP_SHR1:  alu_res = {1'b0, bus.a[WIDTH-1:1]};
      OP_INC:   alu_res = bus.a + WIDTH'(1);
      default:  alu_legal = 1'b0;
    endcase
  end

  // Next state and next output register values
  always_comb begin
    state_d = state_q;
    c_bus_d = c_bus_q;
    z_d     = z_q;
    load_d  = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          done_d = 1'b1;
          if (alu_legal) begin
            c_bus_d = alu_res;
            z_d     = (alu_res == '0);
            load_d  = dest_oh;
            err_d   = ~|dest_oh;
          end
`ifdef ALU_MUL_EN
          else if (bus.op == OP_MUL) begin
            done_d  = 1'b0;
            state_d = S_MUL;
          end
`endif
          else begin
            err_d = 1'b1;
          end
        end
      end
      S_MUL: begin
`ifdef ALU_MUL_EN
        if (mul_done) begin
          done_d  = 1'b1;
          c_bus_d = mul_res;
          z_d     = (mul_res == '0);
          load_d  = dest_q_oh;
          err_d   = ~|dest_q_oh;
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
    endcase
  end

  // State and registered outputs; reset drops any request in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      c_bus_q <= '0;
      load_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      z_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      c_bus_q <= c_bus_d;
      load_q  <= load_d;
      done_q  <= done_d;
      err_q   <= err_d;
      z_q     <= z_d;
    end
  end

  assign bus.C_bus = c_bus_q;
  assign bus.load  = load_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.z     = z_q;
endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential 24-bit ALU that produces the value on the processor's C bus and the one-hot load strobes for the general-purpose registers that capture it. It sits directly upstream of the GPR bank: each GPR takes `C_bus` and one bit of `load`. Single-cycle operations finish one clock after `start`. The optional multiply is iterative and holds `busy` until its result is committed.

## Interface
Parameters:
- `WIDTH`, 24, datapath and C bus width.
- `NREG`, 8, number of destination GPRs; `dest` is $clog2(NREG) bits.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high; sampled on the rising edge of `clk`.
- `start`  in  1  request; accepted only when `busy`=0.
- `op`  in  4  operation code, sampled with `start`.
- `a`, `b`  in  WIDTH  operands, sampled with `start`.
- `dest`  in  $clog2(NREG)  destination GPR index, sampled with `start`.
- `busy`  out  1  high while a multiply is in progress.
- `done`  out  1  one-cycle pulse when a request completes, including illegal requests.
- `C_bus`  out  WIDTH  registered result; holds its last value between operations.
- `load`  out  NREG  one-hot write strobe; high only in the `done` cycle of a legal op.
- `z`  out  1  result==0, registered with `done` and held until the next `done`.
- `err`  out  1  one-cycle pulse coincident with `done` for an illegal or compiled-out op.

## Operation
- Opcodes:
  - 0 PASSA: a
  - 1 ADD: a+b
  - 2 SUB: a−b
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 SHL1: a<<1, zero fill
  - 7 SHR1: a>>1, logical
  - 8 INC: a+1
  - 9 MUL: low WIDTH bits of a×b
  - 10–15: illegal
- Arithmetic is modulo 2^WIDTH; carry-out and the high product bits are discarded.
- FSM states:
  - IDLE: on `start` with op 0–8, register the result and go to IDLE with `done`. On op 9, load the multiplier and go to MUL.
  - MUL: one shift-add step per cycle, WIDTH steps in total. After the last step, commit the result and return to IDLE.
- Illegal op: `done`=1, `err`=1, `load`=0. `C_bus` and `z` keep their previous values.
- `start` while `busy`=1 is ignored and not queued; no side effects.
- A `dest` value ≥ NREG gives `load`=0, and `err`=1 with `done`.
- Reset:
  - `C_bus`=0, `load`=0, `done`=0, `err`=0, `busy`=0, `z`=1, FSM=IDLE.
  - A reset during MUL aborts the multiply and produces no `done` or `load`.
- `start` with `rst` high in the same cycle: reset wins and the request is dropped.

## Timing
- Single-cycle ops, with `start` sampled at edge n:
  - `C_bus`, `load`, `done`, `z` are valid in the cycle after edge n.
  - The GPR captures at edge n+1.
  - A new `start` may be presented in the cycle after edge n and is sampled at edge n+1, giving back-to-back throughput of one op per clock.
- MUL, with `start` sampled at edge n:
  - `busy`=1 in the cycles after edges n..n+WIDTH−1.
  - `done`, `load`, result in the cycle after edge n+WIDTH, where `busy`=0.
  - A new `start` is accepted at edge n+WIDTH+1 or later.
- `load` and `done` are never high for more than one consecutive cycle for the same request.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `ALU_MUL_EN` defined: op 9 is implemented as the iterative multiplier described above.
- `ALU_MUL_EN` undefined:
  - No multiplier logic; `busy` is tied to 0.
  - Op 9 is treated as illegal: one-cycle `done` with `err`=1 and `load`=0.

## Structure
- Shared package `alu_pkg`:
  - opcode enum (`OP_PASSA` … `OP_MUL`)
  - `WIDTH` default
  - FSM state typedef (`S_IDLE`, `S_MUL`)
- Sub-module `alu_mul_seq`:
  - Shift-add multiplier with `start`/`done` handshake, a step counter, and its own `clk`/`rst`.
  - Instantiated only under `ALU_MUL_EN`.
- The top level holds the opcode decode, single-cycle datapath, one-hot `dest` decode and output registers.

## Test plan
- Reset: assert `rst` for 2 cycles. Expect `C_bus`=0, `load`=0, `z`=1, `busy`=0, `done`=0.
- ADD wrap: a=0xFFFFFF, b=0x000002, op=1, dest=3. Next cycle expect `C_bus`=0x000001, `load`=0x08, `done`=1, `z`=0.
- Back-to-back single-cycle ops:
  - SUB with a=5, b=5, dest=0, then SHL1 with a=0x800001, dest=7.
  - Expect `C_bus`=0 with `z`=1 and `load`=0x01, then `C_bus`=0x000002 with `load`=0x80, on consecutive cycles.
- Illegal op: op=12 after a prior result of 0x000001. Expect `done`=1, `err`=1, `load`=0, `C_bus` still 0x000001.
- MUL (with `ALU_MUL_EN`):
  - a=0x001000, b=0x001001, dest=2 → `busy` for 24 cycles, then `C_bus`=0x001000 (0x1001000 truncated) with `load`=0x04.
  - A `start` issued mid-multiply is ignored.
- Reset mid-multiply: assert `rst` at step 10. Expect no `done` or `load`, `busy`=0 on the next cycle, and a fresh ADD accepted immediately after.
